// File: rtl/lcd_pkg.sv
// Shared definitions for blocks that drive the 16-character LCD text engine.
package lcd_pkg;

    localparam int TEXT_W    = 128;
    localparam int LCD_CHARS = 16;

    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_GAP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Scan offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        int j;
        j     = 0;
        valid = |req;
        idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            j   = (int'(ptr) + i) % N_REQ;
            idx = req[j] ? IDX_W'(j) : idx;
        end
    end

endmodule

// File: rtl/lcd_msg_arbiter.sv
// Round-robin arbiter sharing one LCD text engine among several requesters,
// with one send pulse per message, a completion watchdog and an inter-message gap.
module lcd_msg_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TEXT_W         = lcd_pkg::TEXT_W,
    parameter int GAP_CYCLES     = 50000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*TEXT_W-1:0]   req_text,
    output logic [N_REQ-1:0]          grant,
    output logic [N_REQ-1:0]          done,
    output logic                      timeout_err,
    output logic                      busy,
    output logic                      lcd_send,
    output logic [TEXT_W-1:0]         lcd_text,
    input  logic                      lcd_done
);
    import lcd_pkg::*;

    localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    cur_q, cur_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                lcd_done_q;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [N_REQ-1:0]    done_q, done_d;
    logic                timeout_q, timeout_d;
    logic                busy_q, busy_d;
    logic                send_q, send_d;
    logic [TEXT_W-1:0]   text_q, text_d;

    logic                pick_valid;
    logic [IDX_W-1:0]    pick_idx;
    logic                done_rise;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // A level already high when WAIT is entered produces no edge here.
    assign done_rise = lcd_done & ~lcd_done_q;

    // Next-state and registered-output decode.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cur_d     = cur_q;
        cnt_d     = cnt_q;
        text_d    = text_q;
        grant_d   = '0;
        done_d    = '0;
        timeout_d = 1'b0;
        send_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_SEND;
                    cur_d   = pick_idx;
                    ptr_d   = (pick_idx == IDX_LAST) ? '0 : pick_idx + IDX_W'(1);
                    text_d  = req_text[int'(pick_idx)*TEXT_W +: TEXT_W];
                    grant_d = ONE_HOT0 << pick_idx;
                    send_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: begin
                // Completion takes priority over a watchdog expiring in the same cycle.
                if (done_rise) begin
                    done_d  = ONE_HOT0 << cur_q;
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    done_d    = ONE_HOT0 << cur_q;
                    timeout_d = 1'b1;
                    state_d   = ST_GAP;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, counter, edge history and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            cur_q      <= '0;
            cnt_q      <= '0;
            lcd_done_q <= 1'b0;
            grant_q    <= '0;
            done_q     <= '0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
            send_q     <= 1'b0;
            text_q     <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cur_q      <= cur_d;
            cnt_q      <= cnt_d;
            lcd_done_q <= lcd_done;
            grant_q    <= grant_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            busy_q     <= busy_d;
            send_q     <= send_d;
            text_q     <= text_d;
        end
    end

    assign grant       = grant_q;
    assign done        = done_q;
    assign timeout_err = timeout_q;
    assign busy        = busy_q;
    assign lcd_send    = send_q;
    assign lcd_text    = text_q;

endmodule

// File: tb/tb_lcd_msg_arbiter.sv
// Directed self-checking bench for lcd_msg_arbiter (short gap and watchdog).
module tb_lcd_msg_arbiter;

    localparam int N   = 4;
    localparam int TW  = 128;
    localparam int GAP = 8;
    localparam int TO  = 20;

    logic            CLK;
    logic            RST;
    logic [N-1:0]    req;
    logic [N*TW-1:0] req_text;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic            timeout_err;
    logic            busy;
    logic            lcd_send;
    logic [TW-1:0]   lcd_text;
    logic            lcd_done;

    int n_checks;
    int n_fail;

    logic [TW-1:0] hello;
    logic [N-1:0]  g;

    lcd_msg_arbiter #(
        .N_REQ          (N),
        .TEXT_W         (TW),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .req         (req),
        .req_text    (req_text),
        .grant       (grant),
        .done        (done),
        .timeout_err (timeout_err),
        .busy        (busy),
        .lcd_send    (lcd_send),
        .lcd_text    (lcd_text),
        .lcd_done    (lcd_done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        req = '0;
        lcd_done = 1'b0;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_grant"}, 128'(grant), 128'(4'b0000));
        check_eq({tag, "_done"}, 128'(done), 128'(4'b0000));
        check_eq({tag, "_timeout"}, 128'(timeout_err), 128'(1'b0));
        check_eq({tag, "_busy"}, 128'(busy), 128'(1'b0));
        check_eq({tag, "_send"}, 128'(lcd_send), 128'(1'b0));
        check_eq({tag, "_text"}, lcd_text, 128'(0));
    endtask

    task automatic wait_grant(input int budget, output logic [N-1:0] gv);
        gv = '0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (grant != '0) begin
                gv = grant;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy) break;
            tick();
        end
        check_eq("wait_idle", 128'(busy), 128'(1'b0));
    endtask

    // Called in the SEND cycle: engine completes one cycle into WAIT.
    task automatic serve(input string tag, input logic [N-1:0] exp_done);
        tick();
        tick();
        lcd_done = 1'b1;
        tick();
        check_eq(tag, 128'(done), 128'(exp_done));
        lcd_done = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        hello    = "Hello World!    ";
        req_text = '0;
        do_reset();
        check_reset_outputs("reset");

        // Single request, text stability while req_text churns.
        req_text[0 +: TW] = hello;
        req = 4'b0001;
        tick();
        check_eq("single_grant", 128'(grant), 128'(4'b0001));
        check_eq("single_send", 128'(lcd_send), 128'(1'b1));
        check_eq("single_text", lcd_text, hello);
        check_eq("single_busy", 128'(busy), 128'(1'b1));
        req = 4'b0000;
        tick();
        check_eq("single_grant_pulse", 128'(grant), 128'(4'b0000));
        check_eq("single_send_pulse", 128'(lcd_send), 128'(1'b0));
        for (int i = 0; i < 9; i++) begin
            req_text = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                        $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            tick();
        end
        lcd_done = 1'b1;
        tick();
        check_eq("single_done", 128'(done), 128'(4'b0001));
        check_eq("single_no_timeout", 128'(timeout_err), 128'(1'b0));
        check_eq("single_text_hold", lcd_text, hello);
        lcd_done = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check_eq("single_busy_gap", 128'(busy), 128'(1'b1));
        tick();
        check_eq("single_busy_low", 128'(busy), 128'(1'b0));
        check_eq("single_text_idle", lcd_text, hello);

        // Round-robin with all four requesting, then 1001 from ptr 0.
        do_reset();
        for (int k = 0; k < N; k++) req_text[k*TW +: TW] = 128'(k + 1);
        req = 4'b1111;
        for (int k = 0; k < N; k++) begin
            wait_grant(40, g);
            check_eq($sformatf("rr_grant%0d", k), 128'(g), 128'(4'b0001 << k));
            check_eq($sformatf("rr_text%0d", k), lcd_text, 128'(k + 1));
            req[k] = 1'b0;
            serve($sformatf("rr_done%0d", k), 4'b0001 << k);
        end
        req = 4'b1001;
        wait_grant(40, g);
        check_eq("rr2_first", 128'(g), 128'(4'b0001));
        req[0] = 1'b0;
        serve("rr2_done_first", 4'b0001);
        wait_grant(40, g);
        check_eq("rr2_second", 128'(g), 128'(4'b1000));
        req[3] = 1'b0;
        serve("rr2_done_second", 4'b1000);

        // Watchdog: done and timeout_err exactly TO cycles after WAIT entry.
        do_reset();
        req = 4'b0010;
        tick();
        check_eq("to_grant", 128'(grant), 128'(4'b0010));
        req = 4'b0000;
        for (int i = 0; i < TO; i++) tick();
        check_eq("to_done_early", 128'(done), 128'(4'b0000));
        tick();
        check_eq("to_done", 128'(done), 128'(4'b0010));
        check_eq("to_err", 128'(timeout_err), 128'(1'b1));
        tick();
        check_eq("to_err_pulse", 128'(timeout_err), 128'(1'b0));
        check_eq("to_gap_busy", 128'(busy), 128'(1'b1));
        wait_idle(40);

        // Completion edge on the last watchdog cycle wins over timeout.
        req = 4'b0001;
        tick();
        check_eq("tie_grant", 128'(grant), 128'(4'b0001));
        req = 4'b0000;
        for (int i = 0; i < TO; i++) tick();
        lcd_done = 1'b1;
        tick();
        check_eq("tie_done", 128'(done), 128'(4'b0001));
        check_eq("tie_no_err", 128'(timeout_err), 128'(1'b0));
        lcd_done = 1'b0;
        wait_idle(40);

        // Stale high level is not completion.
        lcd_done = 1'b1;
        tick();
        tick();
        req = 4'b0010;
        tick();
        check_eq("stale_grant", 128'(grant), 128'(4'b0010));
        req = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("stale_no_done", 128'(done), 128'(4'b0000));
        end
        lcd_done = 1'b0;
        tick();
        tick();
        check_eq("stale_fall_no_done", 128'(done), 128'(4'b0000));
        lcd_done = 1'b1;
        tick();
        check_eq("stale_done", 128'(done), 128'(4'b0010));
        lcd_done = 1'b0;
        wait_idle(40);

        // Reset mid-WAIT aborts silently and ignores a later engine edge.
        req = 4'b0100;
        tick();
        check_eq("rst_grant", 128'(grant), 128'(4'b0100));
        req = 4'b0000;
        tick();
        tick();
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_reset_outputs("midrst");
        lcd_done = 1'b1;
        tick();
        tick();
        check_eq("midrst_no_done", 128'(done), 128'(4'b0000));
        check_eq("midrst_idle", 128'(busy), 128'(1'b0));
        lcd_done = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
